// File: rtl/chess_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chess_pkg                                                            |
// | Piece codes, sprite ROM geometry and scheduler state encoding.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package chess_pkg;

  typedef enum logic [3:0] {
    EMPTY    = 4'd0,
    W_PAWN   = 4'd1,
    W_KNIGHT = 4'd2,
    W_BISHOP = 4'd3,
    W_ROOK   = 4'd4,
    W_QUEEN  = 4'd5,
    W_KING   = 4'd6,
    B_PAWN   = 4'd7,
    B_KNIGHT = 4'd8,
    B_BISHOP = 4'd9,
    B_ROOK   = 4'd10,
    B_QUEEN  = 4'd11,
    B_KING   = 4'd12
  } piece_code_t;

  localparam int SPR_DIM   = 55;
  localparam int SPR_WORDS = SPR_DIM * SPR_DIM;
  localparam int N_TYPES   = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FETCH = 2'd2,
    S_DRAIN = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/piece_sprite_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_sprite_scheduler_if                                            |
// | Raster, board RAM, sprite ROM and pixel outputs of the scheduler.    |
// | SPRITE_HILITE_EN adds the square-selection inputs.                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface piece_sprite_scheduler_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [5:0]  board_rd_addr;
  logic [3:0]  board_rd_data;
  logic [15:0] rom_address;
  logic [3:0]  rom_q;
  logic        piece_on;
  logic [3:0]  piece_code;
  logic        hilite_on;
`ifdef SPRITE_HILITE_EN
  logic [5:0]  sel_sq;
  logic        sel_valid;

  modport master (
    input  DrawX, DrawY, board_rd_data, rom_q, sel_sq, sel_valid,
    output board_rd_addr, rom_address, piece_on, piece_code, hilite_on
  );
  modport slave (
    output DrawX, DrawY, board_rd_data, rom_q, sel_sq, sel_valid,
    input  board_rd_addr, rom_address, piece_on, piece_code, hilite_on
  );
`else
  modport master (
    input  DrawX, DrawY, board_rd_data, rom_q,
    output board_rd_addr, rom_address, piece_on, piece_code, hilite_on
  );
  modport slave (
    output DrawX, DrawY, board_rd_data, rom_q,
    input  board_rd_addr, rom_address, piece_on, piece_code, hilite_on
  );
`endif
endinterface
`default_nettype wire

// File: rtl/sprite_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_addr_gen                                                      |
// | Combinational piece code / in-square position -> sprite ROM address. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sprite_addr_gen #(
  parameter int SPR_OFS   = 2,
  parameter int SPR_DIM   = chess_pkg::SPR_DIM,
  parameter int SPR_WORDS = chess_pkg::SPR_WORDS
) (
  input  logic                  en,
  input  chess_pkg::piece_code_t code,
  input  logic [5:0]            lx,
  input  logic [5:0]            ly,
  output logic [15:0]           rom_address,
  output logic                  hit
);
  import chess_pkg::*;

  always_comb begin
    hit = en && (code != EMPTY) && (int'(code) <= N_TYPES)
          && (lx >= 6'(SPR_OFS)) && (lx < 6'(SPR_OFS + SPR_DIM))
          && (ly >= 6'(SPR_OFS)) && (ly < 6'(SPR_OFS + SPR_DIM));
    rom_address = '0;
    if (hit) begin
      rom_address = 16'((int'(code) - 1) * SPR_WORDS
                        + (int'(ly) - SPR_OFS) * SPR_DIM
                        + (int'(lx) - SPR_OFS));
    end
  end

endmodule
`default_nettype wire

// File: rtl/piece_sprite_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_sprite_scheduler                                               |
// | Prefetches the next board row in h-blank and shares one sprite ROM   |
// | across all squares. SPRITE_HILITE_EN enables the selection border.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module piece_sprite_scheduler #(
  parameter int BOARD_X0 = 80,
  parameter int BOARD_Y0 = 0,
  parameter int SQ_PITCH = 60,
  parameter int SPR_OFS  = 2,
  parameter int SPR_DIM  = chess_pkg::SPR_DIM,
  parameter int H_FETCH  = 640,
  parameter int TRANSP   = 0
) (
  input  logic                     vga_clk,
  input  logic                     reset,
  piece_sprite_scheduler_if.master bus
);
  import chess_pkg::*;

  localparam int c_H_TOTAL = 800;
  localparam int c_V_TOTAL = 525;
  localparam int c_X_PRE   = (BOARD_X0 == 0) ? c_H_TOTAL - 1 : BOARD_X0 - 1;
  localparam int c_Y_SPAN  = 8 * SQ_PITCH;

  sched_state_t r_state;
  piece_code_t  r_row_buf [8];
  logic [2:0]   r_fcol;
  logic [2:0]   r_row;
  logic [5:0]   r_ly;
  logic         r_row_valid;
  logic [5:0]   r_rd_addr;

  logic         r_in_board;
  logic [2:0]   r_col;
  logic [5:0]   r_lx;

  logic         r_hit_d1;
  piece_code_t  r_code_d1;

  logic [9:0]   w_ny;
  logic [10:0]  w_ny_diff;
  logic         w_ny_in;
  logic [6:0]   w_row_ge;
  logic [2:0]   w_row;
  logic [5:0]   w_ly;
  logic         w_hit;
  logic [15:0]  w_rom_address;
  piece_code_t  w_code;

  // Next line's row and line-in-square from fixed square boundaries,
  // so they are correct on the first prefetch after any reset.
  assign w_ny      = (bus.DrawY == 10'(c_V_TOTAL - 1)) ? 10'd0 : bus.DrawY + 10'd1;
  assign w_ny_diff = {1'b0, w_ny} - 11'(BOARD_Y0);
  assign w_ny_in   = !w_ny_diff[10] && (w_ny_diff[9:0] < 10'(c_Y_SPAN));

  for (genvar k = 1; k < 8; k++) begin : g_row_bound
    assign w_row_ge[k-1] = (w_ny_diff[9:0] >= 10'(k * SQ_PITCH));
  end

  assign w_row = 3'($countones(w_row_ge));
  assign w_ly  = 6'(w_ny_diff[9:0] - 10'(int'(w_row) * SQ_PITCH));

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_row_buf   <= '{default: EMPTY};
      r_fcol      <= '0;
      r_row       <= '0;
      r_ly        <= '0;
      r_row_valid <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.DrawX == 10'(H_FETCH)) r_state <= S_CALC;
        end
        S_CALC: begin
          if (w_ny_in) begin
            r_row       <= w_row;
            r_ly        <= w_ly;
            r_row_valid <= 1'b1;
            r_fcol      <= '0;
            r_rd_addr   <= {w_row, 3'd0};
            r_state     <= S_FETCH;
          end else begin
            r_row_valid <= 1'b0;
            r_row_buf   <= '{default: EMPTY};
            r_state     <= S_IDLE;
          end
        end
        S_FETCH: begin
          // RAM data lags the address by one cycle
          if (r_fcol != 3'd0) r_row_buf[r_fcol - 3'd1] <= piece_code_t'(bus.board_rd_data);
          if (r_fcol == 3'd7) begin
            r_state <= S_DRAIN;
          end else begin
            r_fcol    <= r_fcol + 3'd1;
            r_rd_addr <= {r_row, r_fcol + 3'd1};
          end
        end
        S_DRAIN: begin
          r_row_buf[7] <= piece_code_t'(bus.board_rd_data);
          r_rd_addr    <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Column/lx registers hold the position of the pixel on DrawX this cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_in_board <= 1'b0;
      r_col      <= '0;
      r_lx       <= '0;
    end else if (bus.DrawX == 10'(c_X_PRE)) begin
      r_in_board <= 1'b1;
      r_col      <= '0;
      r_lx       <= '0;
    end else if (r_in_board) begin
      if (r_lx == 6'(SQ_PITCH - 1)) begin
        r_lx  <= '0;
        r_col <= r_col + 3'd1;
        if (r_col == 3'd7) r_in_board <= 1'b0;
      end else begin
        r_lx <= r_lx + 6'd1;
      end
    end
  end

  assign w_code = r_row_buf[r_col];

  sprite_addr_gen #(
    .SPR_OFS   (SPR_OFS),
    .SPR_DIM   (SPR_DIM),
    .SPR_WORDS (SPR_DIM * SPR_DIM)
  ) u_addr_gen (
    .en          (r_in_board && r_row_valid),
    .code        (w_code),
    .lx          (r_lx),
    .ly          (r_ly),
    .rom_address (w_rom_address),
    .hit         (w_hit)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hit_d1  <= 1'b0;
      r_code_d1 <= EMPTY;
    end else begin
      r_hit_d1  <= w_hit;
      r_code_d1 <= w_hit ? w_code : EMPTY;
    end
  end

  assign bus.board_rd_addr = r_rd_addr;
  assign bus.rom_address   = w_rom_address;
  assign bus.piece_on      = r_hit_d1 && (bus.rom_q != 4'(TRANSP));
  assign bus.piece_code    = r_code_d1;

`ifdef SPRITE_HILITE_EN
  logic r_hil_d1;
  logic w_hil;
  logic w_edge_x;
  logic w_edge_y;

  assign w_edge_x = (r_lx < 6'd2) || (r_lx >= 6'(SQ_PITCH - 2));
  assign w_edge_y = (r_ly < 6'd2) || (r_ly >= 6'(SQ_PITCH - 2));
  assign w_hil    = bus.sel_valid && r_in_board && r_row_valid
                    && (bus.sel_sq == {r_row, r_col}) && (w_edge_x || w_edge_y);

  always_ff @(posedge vga_clk) begin
    if (reset) r_hil_d1 <= 1'b0;
    else       r_hil_d1 <= w_hil;
  end

  assign bus.hilite_on = r_hil_d1;
`else
  assign bus.hilite_on = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_piece_sprite_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_piece_sprite_scheduler                                            |
// | Raster driver with expected-value queue and a negedge monitor.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_piece_sprite_scheduler;
  import chess_pkg::*;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  piece_sprite_scheduler_if bus ();

  piece_sprite_scheduler dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int          x;
    int          y;
    bit          spot;
    logic [15:0] addr;
    logic        on;
    logic [3:0]  code;
    logic        hil;
    bit          chk_rd;
    logic [5:0]  rd;
  } exp_t;

  typedef struct {
    int x;
    int y;
    int kind;
    int val;
  } spot_t;

  exp_t        q[$];
  logic [3:0]  board [64];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pf_line = -1;
  logic        p_hit;
  logic [15:0] p_addr;
  logic [3:0]  p_code;
  logic        p_hil;
  logic [5:0]  sel_sq_v = 6'd9;
  logic        sel_valid_v = 1'b0;

  // kind 0: rom_address, 1: piece_on, 2: piece_code (hand-computed)
  spot_t spots [7] = '{
    '{82, 2, 0, 0}, '{136, 2, 0, 54}, '{83, 2, 1, 1}, '{83, 2, 2, 1},
    '{138, 2, 1, 0}, '{556, 476, 0, 36299}, '{556, 475, 0, 36244}
  };

`ifdef SPRITE_HILITE_EN
  assign bus.sel_sq    = sel_sq_v;
  assign bus.sel_valid = sel_valid_v;
`endif

  function automatic logic [3:0] rom_fn(input logic [15:0] a);
    return (a % 7 == 3) ? 4'd0 : 4'd5;
  endfunction

  always @(posedge vga_clk) begin
    bus.board_rd_data <= board[bus.board_rd_addr];
    bus.rom_q         <= rom_fn(bus.rom_address);
  end

  task automatic chk(input string nm, input int x, input int y,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s x=%0d y=%0d got=%0d want=%0d", nm, x, y, act, exp);
    end
  endtask

  function automatic void model(input int x, input int y, input bit have_row,
                                output logic h, output logic [15:0] a,
                                output logic [3:0] c, output logic hl);
    int col, row, lx, ly;
    h = 0; a = 0; c = 0; hl = 0;
    if (have_row && x >= 80 && x < 560 && y < 480) begin
      col = (x - 80) / 60;
      lx  = (x - 80) % 60;
      row = y / 60;
      ly  = y % 60;
      if (board[row*8+col] != 0 && lx >= 2 && lx < 57 && ly >= 2 && ly < 57) begin
        h = 1;
        c = board[row*8+col];
        a = 16'((int'(c) - 1) * 3025 + (ly - 2) * 55 + (lx - 2));
      end
`ifdef SPRITE_HILITE_EN
      hl = sel_valid_v && (int'(sel_sq_v) == row*8+col)
           && (lx < 2 || lx >= 58 || ly < 2 || ly >= 58);
`endif
    end
  endfunction

  task automatic do_reset();
    @(posedge vga_clk); #1;
    reset = 1'b1;
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd0;
    @(posedge vga_clk); #1;
    chk("rst_rom_address", -1, -1, 32'(bus.rom_address), 32'd0);
    chk("rst_piece_on",    -1, -1, 32'(bus.piece_on), 32'd0);
    chk("rst_piece_code",  -1, -1, 32'(bus.piece_code), 32'd0);
    chk("rst_board_addr",  -1, -1, 32'(bus.board_rd_addr), 32'd0);
    chk("rst_hilite_on",   -1, -1, 32'(bus.hilite_on), 32'd0);
    reset   = 1'b0;
    pf_line = -1;
    p_hit = 0; p_addr = 0; p_code = 0; p_hil = 0;
  endtask

  task automatic run_line(input int y, input int rst_x, input bit spot);
    int ny;
    exp_t e;
    logic h, hl;
    logic [15:0] a;
    logic [3:0] c;
    ny = (y == 524) ? 0 : y + 1;
    for (int x = 0; x < 800; x++) begin
      @(posedge vga_clk); #1;
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      reset = (x == rst_x);
      model(x, y, (pf_line == y), h, a, c, hl);
      e.x = x; e.y = y; e.spot = spot; e.addr = a;
      e.on = p_hit && (rom_fn(p_addr) != 4'd0);
      e.code = p_code; e.hil = p_hil;
      e.chk_rd = 0; e.rd = 0;
      if (rst_x >= 0 && x > rst_x) begin
        e.chk_rd = 1;
      end else if (x >= 642 && x <= 649 && ny < 480) begin
        e.chk_rd = 1;
        e.rd = 6'((ny / 60) * 8 + (x - 642));
      end
      q.push_back(e);
      if (x == rst_x) begin
        p_hit = 0; p_addr = 0; p_code = 0; p_hil = 0;
      end else begin
        p_hit = h; p_addr = a; p_code = c; p_hil = hl;
      end
      if (rst_x >= 0 && x == rst_x + 1)
        chk("rst_fsm_idle", x, y, 32'(dut.r_state), 32'(S_IDLE));
    end
    if (rst_x >= 0) pf_line = -1;
    else            pf_line = (ny < 480) ? ny : -1;
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge vga_clk);
      if (q.size() > 0) begin
        m = q.pop_front();
        chk("rom_address", m.x, m.y, 32'(bus.rom_address), 32'(m.addr));
        chk("piece_on",    m.x, m.y, 32'(bus.piece_on), 32'(m.on));
        chk("piece_code",  m.x, m.y, 32'(bus.piece_code), 32'(m.code));
        chk("hilite_on",   m.x, m.y, 32'(bus.hilite_on), 32'(m.hil));
        if (m.chk_rd) chk("board_rd_addr", m.x, m.y, 32'(bus.board_rd_addr), 32'(m.rd));
        if (m.spot) begin
          foreach (spots[i]) begin
            if (spots[i].x == m.x && spots[i].y == m.y) begin
              case (spots[i].kind)
                0:       chk("spot_addr", m.x, m.y, 32'(bus.rom_address), 32'(spots[i].val));
                1:       chk("spot_on",   m.x, m.y, 32'(bus.piece_on), 32'(spots[i].val));
                default: chk("spot_code", m.x, m.y, 32'(bus.piece_code), 32'(spots[i].val));
              endcase
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    foreach (board[i]) board[i] = 4'd0;
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd0;

    // Empty board across the frame wrap
    do_reset();
    foreach (board[i]) board[i] = 4'd0;
    for (int y = 523; y < 525; y++) run_line(y, -1, 0);
    for (int y = 0; y < 3; y++) run_line(y, -1, 0);

    // Pieces on corners and square 9; prefetch of row 0 happens on line 524
    board[0] = 4'd1; board[7] = 4'd6; board[9] = 4'd3; board[63] = 4'd12;
    do_reset();
    run_line(524, -1, 1);
    for (int y = 0; y < 4; y++) run_line(y, -1, 1);

    // Row 0/1 boundary with selection border on square 9
    sel_valid_v = 1'b1;
    do_reset();
    for (int y = 57; y < 62; y++) run_line(y, -1, 0);
    sel_valid_v = 1'b0;
    run_line(62, -1, 0);

    // Bottom-right square and board exit
    do_reset();
    for (int y = 474; y < 482; y++) run_line(y, -1, 1);

    // Reset during FETCH column 3 of line 2's prefetch
    do_reset();
    run_line(1, -1, 0);
    run_line(2, 645, 0);
    run_line(3, -1, 0);
    run_line(4, -1, 0);

    repeat (3) @(negedge vga_clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
